fir4_chan_sched: RTL and testbench

FIR4_CHAN_SCHED -- requirements
Module: fir4_chan_sched

---
 rtl/fir4_chan_sched.sv | 145 ++++++++++++++
 tb/tb_fir4_chan_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir4_chan_sched.sv
// Round-robin scheduler sharing one 4-tap moving-sum/average datapath across NCH channels.
// One result per 3 cycles; result held in OUT until out_ready; no input accepted while busy.
module fir4_chan_sched #(
  parameter int W   = 16,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W+1:0]     out_sum,
  output logic [W-1:0]     out_avg,
  output logic [1:0]       out_ch,
  input  logic             clr_valid,
  input  logic [1:0]       clr_ch
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] hist_q [NCH][4];
  logic [W-1:0] hist_d [NCH][4];
  logic [1:0]   last_grant_q, last_grant_d;
  logic [1:0]   cur_ch_q, cur_ch_d;
  logic         out_valid_q, out_valid_d;
  logic [W+1:0] out_sum_q, out_sum_d;
  logic [1:0]   out_ch_q, out_ch_d;

  logic         grant_vld;
  logic [1:0]   grant_ch;
  logic [W-1:0] sample;
  logic [W+1:0] sum_full;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = last_grant_q;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last_grant_q) + i) % NCH;
      if (!grant_vld && in_valid[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = 2'(idx);
      end
    end
    if (state_q != IDLE || reset) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld) begin
      in_ready[grant_ch] = 1'b1;
    end
  end

  assign sample = in_data[int'(grant_ch)*W +: W];

  // Clear is applied before the shift so a same-edge clear+accept leaves {sample,0,0,0}.
  always_comb begin
    hist_d = hist_q;
    if (clr_valid) begin
      for (int k = 0; k < 4; k++) begin
        hist_d[clr_ch][k] = '0;
      end
    end
    if (grant_vld) begin
      hist_d[grant_ch][3] = hist_d[grant_ch][2];
      hist_d[grant_ch][2] = hist_d[grant_ch][1];
      hist_d[grant_ch][1] = hist_d[grant_ch][0];
      hist_d[grant_ch][0] = sample;
    end
  end

  assign sum_full = {2'b00, hist_q[cur_ch_q][0]} + {2'b00, hist_q[cur_ch_q][1]}
                  + {2'b00, hist_q[cur_ch_q][2]} + {2'b00, hist_q[cur_ch_q][3]};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_ch_d     = cur_ch_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_ch_d     = out_ch_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          cur_ch_d     = grant_ch;
          last_grant_d = grant_ch;
          state_d      = CALC;
        end
      end
      CALC: begin
        out_sum_d   = sum_full;
        out_ch_d    = cur_ch_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'(NCH - 1);
      cur_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_ch_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 4; k++) begin
          hist_q[c][k] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_ch_q     <= cur_ch_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_ch_q     <= out_ch_d;
      hist_q       <= hist_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_avg   = out_sum_q[W+1:2];
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_fir4_chan_sched.sv
// Scoreboard bench for fir4_chan_sched: directed scenarios plus randomized traffic vs a reference model.
module tb_fir4_chan_sched;
  localparam int W   = 16;
  localparam int NCH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]  in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [W+1:0]    out_sum;
  logic [W-1:0]    out_avg;
  logic [1:0]      out_ch;
  logic            clr_valid;
  logic [1:0]      clr_ch;

  always #5 clk = ~clk;

  fir4_chan_sched #(.W(W), .NCH(NCH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_avg(out_avg), .out_ch(out_ch),
    .clr_valid(clr_valid), .clr_ch(clr_ch)
  );

  typedef struct {int ch; int sum;} exp_t;
  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;

  // Reference model: per-channel sample history, arbiter pointer, busy phase.
  int mh[4][4];
  int m_last  = 3;
  int m_phase = 0;
  int cyc     = 0;
  int glog_ch[$];
  int glog_t[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) mh[c][k] = 0;
    m_last  = 3;
    m_phase = 0;
    sb.delete();
    have_cur = 0;
  endtask

  // One clock of stimulus: drive, check in_ready against predicted grant, advance model at the edge.
  task automatic step(input logic [3:0] v, input logic [63:0] d, input logic ordy,
                      input logic cv, input logic [1:0] cc, output int g);
    exp_t e;
    in_valid = v; in_data = d; out_ready = ordy; clr_valid = cv; clr_ch = cc;
    #1;
    g = -1;
    if (m_phase == 0) begin
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_last + i) % 4;
        if (g < 0 && v[c]) g = c;
      end
    end
    chk("in_ready", int'(in_ready), (g >= 0) ? (1 << g) : 0);
    @(posedge clk);
    cyc++;
    if (cv) for (int k = 0; k < 4; k++) mh[cc][k] = 0;
    if (g >= 0) begin
      mh[g][3] = mh[g][2];
      mh[g][2] = mh[g][1];
      mh[g][1] = mh[g][0];
      mh[g][0] = int'(d[g*16 +: 16]);
      e.ch  = g;
      e.sum = mh[g][0] + mh[g][1] + mh[g][2] + mh[g][3];
      sb.push_back(e);
      m_last  = g;
      m_phase = 1;
      glog_ch.push_back(g);
      glog_t.push_back(cyc);
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && ordy) begin
      m_phase = 0;
    end
    #1;
  endtask

  task automatic send(input int ch, input logic [15:0] val, input logic ordy,
                      input logic cv, input logic [1:0] cc);
    int g;
    int n;
    n = 0;
    g = -1;
    while (g != ch && n < 30) begin
      step(4'(1 << ch), {4{val}}, ordy, cv, cc, g);
      n++;
    end
    if (g != ch) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ch %0d not granted within 30 cycles", ch);
    end
  endtask

  task automatic drain();
    int g;
    repeat (4) step(4'h0, 64'h0, 1'b1, 1'b0, 2'd0, g);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 4'hF; in_data = '0; out_ready = 1'b0; clr_valid = 1'b0; clr_ch = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_avg", int'(out_avg), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    in_valid = 4'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops one expectation per result and re-checks it every cycle it is held.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: out_sum=%0d out_ch=%0d with nothing expected", out_sum, out_ch);
          end else begin
            cur = sb.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          chk("out_sum", int'(out_sum), cur.sum);
          chk("out_avg", int'(out_avg), cur.sum >> 2);
          chk("out_ch", int'(out_ch), cur.ch);
          if (out_ready) have_cur = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [63:0] d;
    logic [15:0] lane;

    do_reset();

    // Round-robin with every channel requesting from reset.
    glog_ch.delete(); glog_t.delete();
    for (int i = 0; i < 15; i++) step(4'hF, 64'h0004_0003_0002_0001, 1'b1, 1'b0, 2'd0, g);
    if (glog_ch.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", glog_ch[i], i % 4);
      for (int i = 1; i < 5; i++) chk("rr_spacing", glog_t[i] - glog_t[i-1], 3);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL rr_count: got %0d grants, expected at least 5", glog_ch.size());
    end
    drain();

    // Single-channel ramp from a fresh reset.
    do_reset();
    for (int i = 1; i <= 4; i++) send(0, 16'(i), 1'b1, 1'b0, 2'd0);
    drain();

    // Full-scale samples exercise the two extra sum bits.
    for (int i = 0; i < 4; i++) send(1, 16'hFFFF, 1'b1, 1'b0, 2'd0);
    drain();

    // Backpressure: hold the result for several cycles with requests pending.
    send(3, 16'd9, 1'b0, 1'b0, 2'd0);
    repeat (7) step(4'hF, {4{16'd2}}, 1'b0, 1'b0, 2'd0, g);
    step(4'h0, 64'h0, 1'b1, 1'b0, 2'd0, g);
    step(4'hF, {4{16'd2}}, 1'b1, 1'b0, 2'd0, g);
    drain();

    // Clear coinciding with an accept on the same channel.
    for (int i = 0; i < 4; i++) send(2, 16'd8, 1'b1, 1'b0, 2'd0);
    drain();
    send(2, 16'd5, 1'b1, 1'b1, 2'd2);
    drain();

    // Randomized traffic with backpressure and clears in every state.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) begin
        lane = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
        d[c*16 +: 16] = lane;
      end
      step(4'($urandom), d, ($urandom % 4) != 0, ($urandom % 8) == 0, 2'($urandom), g);
    end
    drain();

    // Reset while a result is held: it must vanish and histories restart at zero.
    send(0, 16'd3, 1'b0, 1'b0, 2'd0);
    repeat (3) step(4'h0, 64'h0, 1'b0, 1'b0, 2'd0, g);
    do_reset();
    chk("post_rst_out_valid", int'(out_valid), 0);
    repeat (3) step(4'h0, 64'h0, 1'b1, 1'b0, 2'd0, g);
    send(0, 16'd7, 1'b1, 1'b0, 2'd0);
    drain();

    chk("sb_empty", sb.size(), 0);
    chk("no_pending", int'(have_cur), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
